// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential radix-2 Booth multiplier shared by two requesters.
//
// Two requesters arbitrate round-robin for a single multiply engine. An
// accepted X*Y takes WIDTH Booth steps (one per clock) and the signed
// 2*WIDTH-bit product is then held on the result port until the consumer
// takes it.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   reqN_valid/reqN_ready requester N handshake (N = 0, 1)
//   reqN_x, reqN_y        signed multiplier X / multiplicand Y of requester N
//   res_valid/res_ready   result handshake
//   res_data              signed product X*Y
//   res_id                requester index that issued the product
//   busy                  engine not in IDLE
module booth_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_x,
    input  logic [WIDTH-1:0]   req0_y,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_x,
    input  logic [WIDTH-1:0]   req1_y,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] res_data,
    output logic               res_id,
    output logic               busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                 state;
    logic                   last_grant;
    logic                   grant;
    logic                   idle_ok;
    logic                   take1;
    logic [CW-1:0]          count;
    // hi carries one guard bit so that subtracting the most negative Y
    // (i.e. adding 2^(WIDTH-1)) cannot overflow.
    logic signed [WIDTH:0]  hi;
    logic signed [WIDTH:0]  y_ext;
    logic [WIDTH-1:0]       lo;
    logic                   e;
    logic                   id;
    logic signed [WIDTH:0]  sum;
    logic signed [WIDTH:0]  hi_nxt;
    logic [WIDTH-1:0]       lo_nxt;

    // Round-robin: a lone requester wins; on a tie the one not served last.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid)
            grant = ~last_grant;
        else if (req1_valid)
            grant = 1'b1;
    end

    assign idle_ok    = rst_n && (state == IDLE);
    assign req0_ready = idle_ok && req0_valid && !grant;
    assign req1_ready = idle_ok && req1_valid && grant;
    assign take1      = req1_ready;
    assign busy       = (state != IDLE);

    // One Booth step: add/subtract Y on the {lo[0],E} pair, then an
    // arithmetic right shift of the {hi,lo} pair.
    always_comb begin
        sum = hi;
        case ({lo[0], e})
            2'b10:   sum = hi - y_ext;
            2'b01:   sum = hi + y_ext;
            default: sum = hi;
        endcase
        hi_nxt = {sum[WIDTH], sum[WIDTH:1]};
        lo_nxt = {sum[0], lo[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            count      <= '0;
            hi         <= '0;
            lo         <= '0;
            e          <= 1'b0;
            y_ext      <= '0;
            id         <= 1'b0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_id     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        hi         <= '0;
                        lo         <= take1 ? req1_x : req0_x;
                        y_ext      <= take1 ? {req1_y[WIDTH-1], req1_y}
                                            : {req0_y[WIDTH-1], req0_y};
                        e          <= 1'b0;
                        count      <= '0;
                        id         <= take1;
                        last_grant <= take1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    hi    <= hi_nxt;
                    lo    <= lo_nxt;
                    e     <= lo[0];
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        state     <= DONE;
                        res_valid <= 1'b1;
                        res_data  <= {hi_nxt[WIDTH-1:0], lo_nxt};
                        res_id    <= id;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
